ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
- Two-requester arbiter and sequencer for the single-port 1024x8 synchronous RAM (ram_1-style port: cs, rd, wr, addr, data_in, d_out).
- Accepts read/write requests from two independent masters and grants them round-robin.
- Drives the RAM control strobes one access at a time and returns read data and a completion ack to the owning master.
- Sits between the two datapath masters and the RAM macro.

Parameters:
- AW, 10, address width (RAM depth 2**AW = 1024).
- DW, 8, data width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 access request (level).
- we0  in  1  requester 0: 1=write, 0=read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  requester 0 request accepted (1-cycle pulse).
- ack0  out  1  requester 0 access complete (1-cycle pulse).
- rdata0  out  DW  requester 0 read data, valid when ack0 for a read, held until next read by requester 0.
- req1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as requester 0, for requester 1.
- ram_cs  out  1  RAM chip select.
- ram_rd  out  1  RAM read strobe.
- ram_wr  out  1  RAM write strobe.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data (valid 1 cycle after the read strobe edge).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, rr pointer last=1 (requester 0 wins the first tie). All outputs 0: gnt*, ack*, rdata*, ram_*.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high at the clock edge, arbitrate, latch owner/we/addr/wdata, and go to ISSUE. Otherwise stay in IDLE.
  - Arbitration: only one requester asserting wins. Both asserting: the requester not equal to last wins, then last := winner.
- ISSUE (1 cycle):
  - gnt_owner=1.
  - ram_cs=1 and ram_addr=latched address.
  - Write: ram_wr=1, ram_rd=0, ram_din=wdata.
  - Read: ram_rd=1, ram_wr=0.
  - Go to WAIT.
- WAIT (1 cycle):
  - ram_cs, ram_rd and ram_wr are 0.
  - Read: ram_dout is valid; capture it into rdata_owner at the end of WAIT.
  - Go to IDLE.
- Completion: ack_owner=1 in the first IDLE cycle after WAIT. rdata is valid in that same cycle.
- A new request can be sampled in the same IDLE cycle in which ack is high.
- Latency: req sampled at edge E → gnt in cycle E+1 → ack in cycle E+3. Peak throughput is one access per 3 cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until it sees gnt.
  - Requester must deassert req by the cycle after gnt (WAIT) unless it wants another access. req high at the next IDLE edge is a new transaction.
  - The non-granted requester keeps req high. It is guaranteed the next grant when it conflicts (no starvation).
- Invariants:
  - ram_rd and ram_wr are never high together.
  - ram_cs is high only in ISSUE.
  - gnt0/gnt1 are mutually exclusive, and so are ack0/ack1.
- Latched fields: inputs changing after acceptance have no effect on the in-flight access.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. A write in ISSUE may or may not have landed; the caller must retry.
- Write ack does not modify rdata.
- Address is passed unmodified; no wrap logic is needed.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - AW/DW defaults.
  - State encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2; 2'd3 is illegal and recovers to IDLE.
- One sub-module: rr_arb2.
  - Inputs: clk, rst_n, req[1:0], advance.
  - Outputs: one-hot grant[1:0] and the last-pointer register.
- The FSM, latches and RAM drive stay in ram_arbiter_2p.

Test Plan:
- Reset then idle: rst_n low for 3 cycles → all outputs 0; no ram_cs while req0=req1=0.
- Single write then read by requester 0:
  - Write addr0=10'h155, wdata0=8'hA5 → gnt0 at +1, ram_cs/ram_wr high for 1 cycle with addr 155/data A5, ack0 at +3.
  - Then read 155 → ack0 with rdata0=8'hA5.
- Simultaneous requests: req0 and req1 held high, both reads, after reset → grants alternate 0,1,0,1 for 4 accesses. No back-to-back grant to the same requester while the other waits.
- Cross-requester data: requester 1 writes 10'h3FF=8'h5A, requester 0 reads 10'h3FF → rdata0=8'h5A. rdata1 is unchanged by requester 0's read.
- Input change after gnt: after gnt1, change addr1/wdata1 → RAM sees the originally latched values.
- Reset mid-access: assert rst_n low during WAIT of a read → no ack. rdata cleared to 0, state IDLE. The next request completes normally in 3 cycles.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package   : ram_ctrl_pkg
// Purpose   : Shared definitions for the two-requester RAM arbiter slice.
//             Holds the default address/data widths, the sequencer state
//             encoding and the two-way round-robin pick function.
// Revision  : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  localparam int c_aw = 10;  // default address width (1024 words)
  localparam int c_dw = 8;   // default data width

  // Sequencer states. The fourth code is never entered; it decodes back to
  // IDLE so a corrupted state register cannot lock the sequencer up.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    BAD   = 2'd3
  } state_t;

  // One-hot winner for two requesters. On a tie the requester that did not
  // win last time gets the grant (last = index of the previous winner).
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] grant;
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_2p_if.sv
`default_nettype none
// ============================================================================
// Interface : ram_arbiter_2p_if
// Purpose   : Bundles the two requester handshakes and the RAM macro port.
//   slave  - seen by the arbiter: takes req*/we*/addr*/wdata*/ram_dout,
//            drives gnt*/ack*/rdata* and the ram_* strobes/address/data.
//   master - seen by the surroundings (both requesters and the RAM macro),
//            the mirror image of slave.
// Revision  : 1.0 - initial release
// ============================================================================
interface ram_arbiter_2p_if
  import ram_ctrl_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int DW = c_dw
);

  // requester 0
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  // requester 1
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  // RAM macro port
  logic          ram_cs;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_dout,
    output gnt0, ack0, rdata0,
    output gnt1, ack1, rdata1,
    output ram_cs, ram_rd, ram_wr, ram_addr, ram_din
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_dout,
    input  gnt0, ack0, rdata0,
    input  gnt1, ack1, rdata1,
    input  ram_cs, ram_rd, ram_wr, ram_addr, ram_din
  );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter_2p_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module    : rr_arb2
// Purpose   : Two-way round-robin arbiter with a registered last-winner
//             pointer. The grant is combinational from req and the pointer;
//             the pointer moves to the winner whenever advance is high and
//             some request is present.
// Ports     : clk, rst_n    - clock, asynchronous active-low reset
//             req[1:0]      - request vector
//             advance       - commit the current winner into the pointer
//             grant[1:0]    - one-hot winner (zero when no request)
//             last          - index of the most recent winner (1 at reset,
//                             so requester 0 wins the first tie)
// Revision  : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last
);

  logic r_last;

  assign grant = rr_pick(req, r_last);
  assign last  = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance && (|req)) begin
      r_last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module    : ram_arbiter_2p
// Purpose   : Arbiter/sequencer sharing one single-port synchronous RAM
//             between two requesters. Requests are granted round-robin and
//             run one at a time through IDLE -> ISSUE -> WAIT -> IDLE:
//               accept edge : owner/op/address/data latched, gnt raised
//               ISSUE       : ram_cs plus ram_rd or ram_wr for one cycle
//               WAIT        : RAM's registered read data becomes valid
//               next IDLE   : ack to the owner, read data on rdata
// Ports     : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - ram_arbiter_2p_if.slave: requester 0/1 handshakes
//                      (req/we/addr/wdata in, gnt/ack/rdata out) and the
//                      RAM port (cs/rd/wr/addr/din out, dout in)
// Revision  : 1.0 - initial release
// ============================================================================
module ram_arbiter_2p
  import ram_ctrl_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int DW = c_dw
)(
  input  logic                clk,
  input  logic                rst_n,
  ram_arbiter_2p_if.slave     bus
);

  state_t        r_state;
  logic          r_owner;      // index of the requester being served
  logic          r_we;         // latched operation of the access in flight
  logic [1:0]    r_gnt;
  logic [1:0]    r_ack;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_ram_cs;
  logic          r_ram_rd;
  logic          r_ram_wr;
  logic [AW-1:0] r_ram_addr;   // also serves as the latched request address
  logic [DW-1:0] r_ram_din;

  logic [1:0]    w_req;
  logic [1:0]    w_grant;
  logic          w_last;
  logic          w_advance;
  logic          w_owner;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_req     = {bus.req1, bus.req0};
  assign w_advance = (r_state == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_advance),
    .grant   (w_grant),
    .last    (w_last)
  );

  // Winner index for the field muxes: a lone requester wins outright, on a
  // tie the one that did not win last time. Agrees with w_grant by design.
  assign w_owner     = (&w_req) ? ~w_last : w_req[1];
  assign w_sel_we    = w_owner ? bus.we1    : bus.we0;
  assign w_sel_addr  = w_owner ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_owner ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ram_cs   <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      // Pulse outputs default low; only the accepting/completing edge sets them.
      r_gnt    <= 2'b00;
      r_ack    <= 2'b00;
      r_ram_cs <= 1'b0;
      r_ram_rd <= 1'b0;
      r_ram_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            // Everything the access needs is captured here, so requester
            // inputs are free to change from the grant cycle onwards.
            r_state    <= ISSUE;
            r_owner    <= w_owner;
            r_we       <= w_sel_we;
            r_gnt      <= w_grant;
            r_ram_cs   <= 1'b1;
            r_ram_wr   <= w_sel_we;
            r_ram_rd   <= ~w_sel_we;
            r_ram_addr <= w_sel_addr;
            if (w_sel_we) begin
              r_ram_din <= w_sel_wdata;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // RAM read data is valid during WAIT; a write leaves rdata alone.
          r_state        <= IDLE;
          r_ack[r_owner] <= 1'b1;
          if (!r_we) begin
            if (r_owner) begin
              r_rdata1 <= bus.ram_dout;
            end else begin
              r_rdata0 <= bus.ram_dout;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0     = r_gnt[0];
  assign bus.gnt1     = r_gnt[1];
  assign bus.ack0     = r_ack[0];
  assign bus.ack1     = r_ack[1];
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.ram_cs   = r_ram_cs;
  assign bus.ram_rd   = r_ram_rd;
  assign bus.ram_wr   = r_ram_wr;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module    : tb_ram_arbiter_2p
// Purpose   : Self-checking bench for ram_arbiter_2p. A transaction-level
//             reference model turns the requests it sees into expected
//             grants and completions; a monitor compares them with the DUT.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_2p;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ram_arbiter_2p_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter_2p #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int            cyc;
    int            who;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } ack_exp_t;

  gnt_exp_t gq[$];
  ack_exp_t aq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ RAM
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_cs && bus.ram_wr) ram_mem[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_cs && bus.ram_rd) bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  // ------------------------------------------------------- reference model
  // One access at a time: an accepted request occupies the RAM for the next
  // two edges, so the third edge after acceptance may accept again. Grant is
  // seen in the cycle after acceptance, ack two cycles after that.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_rd  [0:1];
  int m_busy;
  int m_last;
  initial begin
    gnt_exp_t      e;
    ack_exp_t      a;
    int            w;
    logic          r0, r1, mwe;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    m_busy = 0; m_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        gq.delete(); aq.delete();
        m_busy = 0; m_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
      end else begin
        cyc++;
        if (m_busy > 0) begin
          m_busy--;
        end else begin
          r0 = bus.req0; r1 = bus.req1;
          if (r0 || r1) begin
            if (r0 && r1) w = (m_last == 0) ? 1 : 0;
            else          w = r1 ? 1 : 0;
            m_last = w;
            mwe = (w == 0) ? bus.we0    : bus.we1;
            ad  = (w == 0) ? bus.addr0  : bus.addr1;
            wd  = (w == 0) ? bus.wdata0 : bus.wdata1;
            if (mwe) ref_mem[ad] = wd;
            else     ref_rd[w]   = ref_mem[ad];
            e.cyc = cyc; e.who = w; e.we = mwe; e.addr = ad; e.wdata = wd;
            gq.push_back(e);
            a.cyc = cyc + 2; a.who = w; a.rd0 = ref_rd[0]; a.rd1 = ref_rd[1];
            aq.push_back(a);
            m_busy = 2;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- monitor
  initial begin
    gnt_exp_t ge;
    ack_exp_t ae;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rd_wr_exclusive", 64'(bus.ram_rd & bus.ram_wr), 0);
        chk("gnt_exclusive",   64'(bus.gnt0 & bus.gnt1), 0);
        chk("ack_exclusive",   64'(bus.ack0 & bus.ack1), 0);
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
          ge = gq.pop_front();
          chk("gnt_missing_at", 64'(cyc), 64'(ge.cyc));
        end
        while (aq.size() > 0 && aq[0].cyc < cyc) begin
          ae = aq.pop_front();
          chk("ack_missing_at", 64'(cyc), 64'(ae.cyc));
        end
        if (bus.gnt0 || bus.gnt1 || bus.ram_cs) begin
          if (gq.size() == 0) begin
            chk("gnt_unexpected", {bus.ram_cs, bus.gnt1, bus.gnt0}, 0);
          end else begin
            ge = gq.pop_front();
            chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
            chk("gnt_who", {bus.gnt1, bus.gnt0}, (ge.who == 1) ? 2'b10 : 2'b01);
            chk("ram_cs", bus.ram_cs, 1);
            chk("ram_wr", bus.ram_wr, ge.we);
            chk("ram_rd", bus.ram_rd, !ge.we);
            chk("ram_addr", bus.ram_addr, ge.addr);
            if (ge.we) chk("ram_din", bus.ram_din, ge.wdata);
          end
        end
        if (bus.ack0 || bus.ack1) begin
          if (aq.size() == 0) begin
            chk("ack_unexpected", {bus.ack1, bus.ack0}, 0);
          end else begin
            ae = aq.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
            chk("ack_who", {bus.ack1, bus.ack0}, (ae.who == 1) ? 2'b10 : 2'b01);
            chk("rdata0", bus.rdata0, ae.rd0);
            chk("rdata1", bus.rdata1, ae.rd1);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic set_req(input int r, input logic rq, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (r == 0) begin
      bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic gnt_of(input int r);
    return (r == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  // Called at a negedge; returns at the negedge of the grant cycle with req
  // dropped (and, when scramble is set, every other field inverted).
  task automatic do_access(input int r, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit scramble);
    int t;
    t = 0;
    set_req(r, 1'b1, we, a, d);
    do begin
      @(negedge clk);
      t++;
    end while (!gnt_of(r) && t < 40);
    chk($sformatf("gnt_wait_r%0d", r), gnt_of(r), 1);
    if (scramble) set_req(r, 1'b0, !we, ~a, ~d);
    else          set_req(r, 1'b0, we, a, d);
  endtask

  task automatic rand_traffic(input int r, input int n);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      we = 1'($urandom_range(0, 1));
      a  = AW'(10'h100 + $urandom_range(0, 7));
      d  = DW'($urandom);
      do_access(r, we, a, d, 1'($urandom_range(0, 1)));
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.rdata0, bus.rdata1,
                bus.ram_cs, bus.ram_rd, bus.ram_wr, bus.ram_addr, bus.ram_din});
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("reset_outputs", all_outputs(), 0);
    end
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    apply_reset(3);
    repeat (5) @(negedge clk);

    // single write then read by requester 0
    do_access(0, 1'b1, 10'h155, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    do_access(0, 1'b0, 10'h155, 8'h00, 1'b0);
    repeat (4) @(negedge clk);

    // both requesters reading continuously: grants must alternate 0,1,0,1
    apply_reset(3);
    fork
      for (int i = 0; i < 4; i++) do_access(0, 1'b0, 10'h155, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) do_access(1, 1'b0, 10'h3FF, 8'h00, 1'b0);
    join
    repeat (4) @(negedge clk);

    // cross-requester data
    do_access(1, 1'b1, 10'h3FF, 8'h5A, 1'b0);
    do_access(0, 1'b0, 10'h3FF, 8'h00, 1'b0);
    repeat (4) @(negedge clk);

    // inputs change right after gnt
    do_access(1, 1'b1, 10'h0AA, 8'h3C, 1'b1);
    do_access(1, 1'b0, 10'h0AA, 8'h00, 1'b1);
    repeat (4) @(negedge clk);

    // reset during WAIT of a read: no ack, outputs cleared, next access normal
    do_access(0, 1'b0, 10'h155, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midreset_outputs", all_outputs(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("midreset_outputs", all_outputs(), 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_access(0, 1'b0, 10'h155, 8'h00, 1'b0);
    repeat (4) @(negedge clk);

    // random contention
    fork
      rand_traffic(0, 25);
      rand_traffic(1, 25);
    join

    repeat (10) @(negedge clk);
    chk("gnt_queue_drained", 64'(gq.size()), 0);
    chk("ack_queue_drained", 64'(aq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
